dma_cpld_hdr_queue: RTL and testbench

- Response-queue front end downstream of the DMA BD request receiver.
- Accepts 96-bit completion (CplD) headers tagged with a 2-bit channel number (tdest) and holds them in four per-channel FIFOs.
- Drains the FIFOs round-robin onto one registered AXI-Stream port that feeds the completion generator.
- The input has no tready, so overflow is detected and flagged rather than back-pressured.

---
 rtl/dma_pkg.sv | 25 ++
 rtl/dma_hdr_fifo.sv | 64 ++++++
 rtl/dma_cpld_hdr_queue.sv | 138 +++++++++++++
 tb/tb_dma_cpld_hdr_queue.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// dma_pkg: shared DMA channel constants and the round-robin channel helper.
// Revision: 1.0
`default_nettype none

package dma_pkg;

  localparam int NUM_CH     = 4;
  localparam int CPLD_HDR_W = 96;
  localparam int CH_ID_W    = 2;

  typedef logic [CH_ID_W-1:0] ch_id_t;

  localparam ch_id_t CH0_S2C = 2'd0;
  localparam ch_id_t CH0_C2S = 2'd1;
  localparam ch_id_t CH1_S2C = 2'd2;
  localparam ch_id_t CH1_C2S = 2'd3;

  // Channel reached by stepping 'off' places after 'ptr', wrapping modulo NUM_CH.
  function automatic ch_id_t ch_step(input ch_id_t ptr, input int unsigned off);
    return ptr + ch_id_t'(off);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dma_hdr_fifo.sv
// dma_hdr_fifo: single-channel synchronous header FIFO with fill level.
// Revision: 1.0
`default_nettype none

module dma_hdr_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 96,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic [CNT_W-1:0] level,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;

  assign empty = (level == '0);
  assign full  = (level == CNT_W'(DEPTH));
  assign rd_en = pop && !empty;
  // A full FIFO still takes a write when its head leaves in the same cycle.
  assign wr_en = push && (!full || rd_en);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   level <= level + CNT_W'(1);
        2'b01:   level <= level - CNT_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/dma_cpld_hdr_queue.sv
// dma_cpld_hdr_queue: four per-channel CplD header FIFOs drained round-robin onto one
// registered AXI-Stream port. Optional per-channel drop counters: DMA_CPLD_HDR_STATS_EN.
// Revision: 1.0
`default_nettype none

module dma_cpld_hdr_queue
  import dma_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                    user_clk,
  input  logic                    user_reset,
  input  logic [CPLD_HDR_W-1:0]   s_axis_cpld_header_tdata,
  input  logic [CH_ID_W-1:0]      s_axis_cpld_header_tdest,
  input  logic                    s_axis_cpld_header_tvalid,
  output logic [CPLD_HDR_W-1:0]   m_axis_cpld_hdr_tdata,
  output logic [CH_ID_W-1:0]      m_axis_cpld_hdr_tdest,
  output logic                    m_axis_cpld_hdr_tvalid,
  input  logic                    m_axis_cpld_hdr_tready,
  output logic [NUM_CH*CNT_W-1:0] ch_level,
  output logic [NUM_CH-1:0]       ch_overflow,
`ifdef DMA_CPLD_HDR_STATS_EN
  output logic [NUM_CH*16-1:0]    hdr_drop_cnt,
`endif
  input  logic [NUM_CH-1:0]       overflow_clr
);

  logic [CPLD_HDR_W-1:0] fifo_head  [NUM_CH];
  logic [CNT_W-1:0]      fifo_level [NUM_CH];
  logic [NUM_CH-1:0]     fifo_full;
  logic [NUM_CH-1:0]     fifo_empty;
  logic [NUM_CH-1:0]     push_vec;
  logic [NUM_CH-1:0]     pop_vec;
  logic [NUM_CH-1:0]     drop_vec;

  ch_id_t rr_ptr;
  ch_id_t grant;
  ch_id_t cand;
  logic   grant_valid;
  logic   load_en;

  assign load_en = !m_axis_cpld_hdr_tvalid || m_axis_cpld_hdr_tready;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign push_vec[c] = s_axis_cpld_header_tvalid &&
                         (s_axis_cpld_header_tdest == CH_ID_W'(c));
    assign drop_vec[c] = push_vec[c] && fifo_full[c] && !pop_vec[c];
    assign ch_level[c*CNT_W +: CNT_W] = fifo_level[c];

    dma_hdr_fifo #(
      .DEPTH (DEPTH),
      .W     (CPLD_HDR_W),
      .CNT_W (CNT_W)
    ) u_fifo (
      .clk   (user_clk),
      .rst   (user_reset),
      .push  (push_vec[c]),
      .pop   (pop_vec[c]),
      .din   (s_axis_cpld_header_tdata),
      .dout  (fifo_head[c]),
      .level (fifo_level[c]),
      .full  (fifo_full[c]),
      .empty (fifo_empty[c])
    );
  end

  // Search starts one past the last grant; offset NUM_CH lands back on rr_ptr itself.
  always_comb begin
    grant_valid = 1'b0;
    grant       = rr_ptr;
    cand        = rr_ptr;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = ch_step(rr_ptr, i);
      if (!grant_valid && !fifo_empty[cand]) begin
        grant_valid = 1'b1;
        grant       = cand;
      end
    end
  end

  always_comb begin
    pop_vec = '0;
    if (load_en && grant_valid) begin
      pop_vec[grant] = 1'b1;
    end
  end

  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      m_axis_cpld_hdr_tvalid <= 1'b0;
      m_axis_cpld_hdr_tdata  <= '0;
      m_axis_cpld_hdr_tdest  <= '0;
      rr_ptr                 <= CH1_C2S;
    end else if (load_en) begin
      if (grant_valid) begin
        m_axis_cpld_hdr_tvalid <= 1'b1;
        m_axis_cpld_hdr_tdata  <= fifo_head[grant];
        m_axis_cpld_hdr_tdest  <= grant;
        rr_ptr                 <= grant;
      end else begin
        m_axis_cpld_hdr_tvalid <= 1'b0;
      end
    end
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      ch_overflow <= '0;
    end else begin
      ch_overflow <= (ch_overflow & ~overflow_clr) | drop_vec;
    end
  end

`ifdef DMA_CPLD_HDR_STATS_EN
  for (genvar c = 0; c < NUM_CH; c++) begin : g_stats
    logic [15:0] drop_cnt;

    always_ff @(posedge user_clk or posedge user_reset) begin
      if (user_reset) begin
        drop_cnt <= '0;
      end else if (drop_vec[c]) begin
        if (drop_cnt != 16'hFFFF) begin
          drop_cnt <= drop_cnt + 16'd1;
        end
      end else if (overflow_clr[c]) begin
        drop_cnt <= '0;
      end
    end

    assign hdr_drop_cnt[c*16 +: 16] = drop_cnt;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dma_cpld_hdr_queue.sv
// tb_dma_cpld_hdr_queue: directed self-checking bench for dma_cpld_hdr_queue.
// Revision: 1.0
`default_nettype none

module tb_dma_cpld_hdr_queue;

  localparam int DEPTH = 16;
  localparam int CNT_W = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [95:0]   s_tdata;
  logic [1:0]    s_tdest;
  logic          s_tvalid;
  logic [95:0]   m_tdata;
  logic [1:0]    m_tdest;
  logic          m_tvalid;
  logic          m_tready;
  logic [19:0]   ch_level;
  logic [3:0]    ch_overflow;
  logic [3:0]    overflow_clr;
`ifdef DMA_CPLD_HDR_STATS_EN
  logic [63:0]   hdr_drop_cnt;
`endif

  int tests = 0;
  int fails = 0;

  dma_cpld_hdr_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .user_clk                  (clk),
    .user_reset                (rst),
    .s_axis_cpld_header_tdata  (s_tdata),
    .s_axis_cpld_header_tdest  (s_tdest),
    .s_axis_cpld_header_tvalid (s_tvalid),
    .m_axis_cpld_hdr_tdata     (m_tdata),
    .m_axis_cpld_hdr_tdest     (m_tdest),
    .m_axis_cpld_hdr_tvalid    (m_tvalid),
    .m_axis_cpld_hdr_tready    (m_tready),
    .ch_level                  (ch_level),
    .ch_overflow               (ch_overflow),
`ifdef DMA_CPLD_HDR_STATS_EN
    .hdr_drop_cnt              (hdr_drop_cnt),
`endif
    .overflow_clr              (overflow_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [95:0] mkhdr(input int ch, input int k);
    return 96'(32'h5000 + ch * 256 + k);
  endfunction

  function automatic logic [4:0] lvl(input int ch);
    return ch_level[ch*CNT_W +: CNT_W];
  endfunction

  task automatic push_one(input logic [1:0] ch, input logic [95:0] d);
    s_tvalid = 1'b1;
    s_tdest  = ch;
    s_tdata  = d;
    tick();
    s_tvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tdest = '0;
    m_tready = 1'b0; overflow_clr = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid got %0b want 0", m_tvalid); end
    tests++; if (m_tdata !== 96'h0) begin fails++; $display("FAIL reset_tdata got %h want 0", m_tdata); end
    tests++; if (m_tdest !== 2'd0) begin fails++; $display("FAIL reset_tdest got %0d want 0", m_tdest); end
    tests++; if (ch_level !== 20'h0) begin fails++; $display("FAIL reset_level got %h want 0", ch_level); end
    tests++; if (ch_overflow !== 4'h0) begin fails++; $display("FAIL reset_ovf got %b want 0", ch_overflow); end
  endtask

  task automatic test_latency();
    m_tready = 1'b1;
    push_one(2'd2, 96'hAAAAAAAA_AAAAAAAA_AAAAAAAA);
    tests++; if (lvl(2) !== 5'd1) begin fails++; $display("FAIL lat_level1 got %0d want 1", lvl(2)); end
    tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL lat_early_tvalid got %0b want 0", m_tvalid); end
    tick();
    tests++; if (m_tvalid !== 1'b1) begin fails++; $display("FAIL lat_tvalid got %0b want 1", m_tvalid); end
    tests++; if (m_tdata !== 96'hAAAAAAAA_AAAAAAAA_AAAAAAAA) begin fails++; $display("FAIL lat_tdata got %h want aaaa..", m_tdata); end
    tests++; if (m_tdest !== 2'd2) begin fails++; $display("FAIL lat_tdest got %0d want 2", m_tdest); end
    tests++; if (lvl(2) !== 5'd0) begin fails++; $display("FAIL lat_level0 got %0d want 0", lvl(2)); end
    tick();
    tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL lat_drain got %0b want 0", m_tvalid); end
  endtask

  task automatic test_round_robin();
    logic [1:0] chs [3];
    int got;
    chs[0] = 2'd0; chs[1] = 2'd1; chs[2] = 2'd3;
    m_tready = 1'b0;
    for (int c = 0; c < 3; c++)
      for (int k = 0; k < 3; k++)
        push_one(chs[c], mkhdr(int'(chs[c]), k));
    m_tready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 40 && got < 9; cyc++) begin
      if (m_tvalid) begin
        tests++;
        if (m_tdest !== chs[got % 3] || m_tdata !== mkhdr(int'(chs[got % 3]), got / 3)) begin
          fails++;
          $display("FAIL rr_order[%0d] got ch%0d %h want ch%0d %h", got, m_tdest, m_tdata,
                   chs[got % 3], mkhdr(int'(chs[got % 3]), got / 3));
        end
        got++;
      end
      tick();
    end
    tests++; if (got !== 9) begin fails++; $display("FAIL rr_count got %0d want 9", got); end
  endtask

  task automatic test_overflow();
    m_tready = 1'b0;
    push_one(2'd0, mkhdr(0, 7));
    tick();
    for (int k = 0; k < 16; k++) push_one(2'd1, mkhdr(1, k));
    tests++; if (lvl(1) !== 5'd16) begin fails++; $display("FAIL ovf_fill got %0d want 16", lvl(1)); end
    tests++; if (ch_overflow !== 4'b0000) begin fails++; $display("FAIL ovf_early got %b want 0000", ch_overflow); end
    push_one(2'd1, 96'hDEAD1);
    tests++; if (ch_overflow !== 4'b0010) begin fails++; $display("FAIL ovf_set got %b want 0010", ch_overflow); end
    tests++; if (lvl(1) !== 5'd16) begin fails++; $display("FAIL ovf_level got %0d want 16", lvl(1)); end
    overflow_clr = 4'b0010;
    push_one(2'd1, 96'hDEAD2);
    overflow_clr = 4'b0000;
    tests++; if (ch_overflow !== 4'b0010) begin fails++; $display("FAIL ovf_set_wins got %b want 0010", ch_overflow); end
    overflow_clr = 4'b0010;
    tick();
    overflow_clr = 4'b0000;
    tests++; if (ch_overflow !== 4'b0000) begin fails++; $display("FAIL ovf_clr got %b want 0000", ch_overflow); end
  endtask

  task automatic test_full_push_pop();
    int got;
    logic [95:0] exp_d;
    tests++; if (m_tvalid !== 1'b1 || m_tdest !== 2'd0 || m_tdata !== mkhdr(0, 7)) begin
      fails++; $display("FAIL full_hold got v%0b ch%0d %h want v1 ch0 %h", m_tvalid, m_tdest, m_tdata, mkhdr(0, 7));
    end
    m_tready = 1'b1;
    push_one(2'd1, 96'hBEEF);
    tests++; if (lvl(1) !== 5'd16) begin fails++; $display("FAIL full_level got %0d want 16", lvl(1)); end
    tests++; if (ch_overflow !== 4'b0000) begin fails++; $display("FAIL full_ovf got %b want 0000", ch_overflow); end
    got = 0;
    for (int cyc = 0; cyc < 40 && got < 17; cyc++) begin
      if (m_tvalid) begin
        exp_d = (got < 16) ? mkhdr(1, got) : 96'hBEEF;
        tests++;
        if (m_tdest !== 2'd1 || m_tdata !== exp_d) begin
          fails++; $display("FAIL full_drain[%0d] got ch%0d %h want ch1 %h", got, m_tdest, m_tdata, exp_d);
        end
        got++;
      end
      tick();
    end
    tests++; if (got !== 17) begin fails++; $display("FAIL full_count got %0d want 17", got); end
    tests++; if (m_tvalid !== 1'b0 || ch_level !== 20'h0) begin
      fails++; $display("FAIL full_empty got v%0b lvl %h want v0 lvl 0", m_tvalid, ch_level);
    end
  endtask

  task automatic test_back_pressure();
    m_tready = 1'b0;
    push_one(2'd3, 96'h1111);
    push_one(2'd3, 96'h2222);
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (m_tvalid !== 1'b1 || m_tdest !== 2'd3 || m_tdata !== 96'h1111) begin
        fails++; $display("FAIL bp_hold[%0d] got v%0b ch%0d %h want v1 ch3 1111", i, m_tvalid, m_tdest, m_tdata);
      end
      tick();
    end
    m_tready = 1'b1;
    tick();
    tests++; if (m_tvalid !== 1'b1 || m_tdata !== 96'h2222) begin
      fails++; $display("FAIL bp_next got v%0b %h want v1 2222", m_tvalid, m_tdata);
    end
    tick();
    tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL bp_empty got %0b want 0", m_tvalid); end
  endtask

  task automatic test_reset_mid();
    m_tready = 1'b0;
    for (int k = 0; k < 6; k++) push_one(2'd2, mkhdr(2, k));
    tests++; if (lvl(2) !== 5'd5 || m_tvalid !== 1'b1) begin
      fails++; $display("FAIL rst_pre got lvl %0d v%0b want lvl 5 v1", lvl(2), m_tvalid);
    end
    rst = 1'b1;
    #1;
    tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL rst_tvalid got %0b want 0", m_tvalid); end
    tests++; if (ch_level !== 20'h0) begin fails++; $display("FAIL rst_level got %h want 0", ch_level); end
    tick();
    rst = 1'b0;
    m_tready = 1'b1;
    push_one(2'd1, 96'h1234);
    tests++; if (lvl(1) !== 5'd1 || m_tvalid !== 1'b0) begin
      fails++; $display("FAIL rst_after1 got lvl %0d v%0b want lvl 1 v0", lvl(1), m_tvalid);
    end
    tick();
    tests++; if (m_tvalid !== 1'b1 || m_tdest !== 2'd1 || m_tdata !== 96'h1234) begin
      fails++; $display("FAIL rst_after2 got v%0b ch%0d %h want v1 ch1 1234", m_tvalid, m_tdest, m_tdata);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_round_robin();
    test_overflow();
    test_full_push_pop();
    test_back_pressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
